// File: rtl/helix_pkg.sv
// Shared types and default tuning for the helix precision scheduler.
package helix_pkg;
  localparam int PRECISION_W      = 2;
  localparam int FEEDBACK_W       = 16;
  localparam int PREC_UP_THRESH   = 1000;
  localparam int PREC_DOWN_THRESH = 100;

  typedef enum logic [PRECISION_W-1:0] {
    PREC_0 = 2'd0,
    PREC_1 = 2'd1,
    PREC_2 = 2'd2,
    PREC_3 = 2'd3
  } precision_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DWELL,
    ST_EVAL,
    ST_DRAIN
  } sched_state_e;
endpackage

// File: rtl/helix_inflight_tracker.sv
// Saturating up/down counter of contexts accepted but not yet emitted.
module helix_inflight_tracker #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/helix_precision_sched.sv
// Feedback-driven precision scheduler: watches a window of action handshakes,
// tracks peak |feedback|, and steps precision up or down once the reactor drains.
module helix_precision_sched #(
  parameter int FEEDBACK_W  = helix_pkg::FEEDBACK_W,
  parameter int DWELL_N     = 16,
  parameter int UP_THRESH   = helix_pkg::PREC_UP_THRESH,
  parameter int DOWN_THRESH = helix_pkg::PREC_DOWN_THRESH,
  parameter int DRAIN_MAX   = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ctrl_en,
  input  logic                         ctx_valid,
  input  logic                         ctx_ready,
  input  logic                         thought_valid,
  input  logic                         thought_ready,
  input  logic                         action_valid,
  input  logic                         action_ready,
  input  logic                         feedback_valid,
  input  logic signed [FEEDBACK_W-1:0] feedback_delta,
  output logic [1:0]                   precision_mode,
  output logic                         mode_change,
  output logic [3:0]                   inflight,
  output logic                         drain_timeout
);
  import helix_pkg::*;

  localparam int WIN_W = $clog2(DWELL_N + 1);
  localparam int DRN_W = $clog2(DRAIN_MAX + 1);
  localparam int MAG_W = FEEDBACK_W - 1;
  localparam logic [WIN_W-1:0] DWELL_T = WIN_W'(DWELL_N);
  localparam logic [DRN_W-1:0] DRAIN_T = DRN_W'(DRAIN_MAX);
  localparam logic [MAG_W-1:0] UP_T    = MAG_W'(UP_THRESH);
  localparam logic [MAG_W-1:0] DOWN_T  = MAG_W'(DOWN_THRESH);

  sched_state_e     state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [MAG_W-1:0] peak_q, peak_d;
  logic [DRN_W-1:0] drain_cnt_q, drain_cnt_d;
  precision_e       mode_q, mode_d, target_q, target_d;
  logic             mode_change_q, mode_change_d;
  logic             drain_timeout_q, drain_timeout_d;

  logic [FEEDBACK_W-1:0] fb_neg;
  logic [MAG_W-1:0]      fb_mag, peak_fold;
  logic                  eval_up, eval_down;
  logic [3:0]            inflight_cnt;

  helix_inflight_tracker #(.W(4)) u_inflight (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctx_valid && ctx_ready),
    .dec   (thought_valid && thought_ready),
    .count (inflight_cnt)
  );

  // The most negative input has no positive twin, so it clamps to full scale.
  always_comb begin
    fb_neg = {FEEDBACK_W{1'b0}} - feedback_delta;
    if (!feedback_delta[FEEDBACK_W-1]) begin
      fb_mag = feedback_delta[MAG_W-1:0];
    end else if (fb_neg[FEEDBACK_W-1]) begin
      fb_mag = '1;
    end else begin
      fb_mag = fb_neg[MAG_W-1:0];
    end
    peak_fold = (feedback_valid && (fb_mag > peak_q)) ? fb_mag : peak_q;
    eval_up   = (peak_q >= UP_T) && (mode_q != PREC_3);
    eval_down = (peak_q < DOWN_T) && (mode_q != PREC_0);
  end

  always_comb begin
    state_d         = state_q;
    win_cnt_d       = win_cnt_q;
    peak_d          = peak_q;
    drain_cnt_d     = drain_cnt_q;
    mode_d          = mode_q;
    target_d        = target_q;
    mode_change_d   = 1'b0;
    drain_timeout_d = drain_timeout_q;
    if (!ctrl_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_DWELL;
          win_cnt_d   = '0;
          peak_d      = '0;
          drain_cnt_d = '0;
        end
        ST_DWELL: begin
          peak_d = peak_fold;
          if (action_valid && action_ready) begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            if (win_cnt_d == DWELL_T) state_d = ST_EVAL;
          end
        end
        ST_EVAL: begin
          win_cnt_d   = '0;
          peak_d      = '0;
          drain_cnt_d = '0;
          if (eval_up) begin
            target_d = precision_e'(mode_q + 2'd1);
            state_d  = ST_DRAIN;
          end else if (eval_down) begin
            target_d = precision_e'(mode_q - 2'd1);
            state_d  = ST_DRAIN;
          end else begin
            state_d = ST_DWELL;
          end
        end
        default: begin
          drain_cnt_d = drain_cnt_q + DRN_W'(1);
          // Switch when the reactor is empty, or give up waiting after DRAIN_MAX cycles.
          if ((inflight_cnt == 4'd0) || (drain_cnt_d == DRAIN_T)) begin
            if (inflight_cnt != 4'd0) drain_timeout_d = 1'b1;
            mode_d        = target_q;
            mode_change_d = 1'b1;
            state_d       = ST_DWELL;
            win_cnt_d     = '0;
            peak_d        = '0;
            drain_cnt_d   = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      win_cnt_q       <= '0;
      peak_q          <= '0;
      drain_cnt_q     <= '0;
      mode_q          <= PREC_0;
      target_q        <= PREC_0;
      mode_change_q   <= 1'b0;
      drain_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      win_cnt_q       <= win_cnt_d;
      peak_q          <= peak_d;
      drain_cnt_q     <= drain_cnt_d;
      mode_q          <= mode_d;
      target_q        <= target_d;
      mode_change_q   <= mode_change_d;
      drain_timeout_q <= drain_timeout_d;
    end
  end

  assign precision_mode = mode_q;
  assign mode_change    = mode_change_q;
  assign inflight       = inflight_cnt;
  assign drain_timeout  = drain_timeout_q;
endmodule

// File: tb/tb_helix_precision_sched.sv
// Directed bench for helix_precision_sched with a pulse scoreboard.
module tb_helix_precision_sched;
  logic clk = 1'b0;
  logic rst_n, ctrl_en;
  logic ctx_valid, ctx_ready, thought_valid, thought_ready;
  logic action_valid, action_ready, feedback_valid;
  logic signed [15:0] feedback_delta;
  logic [1:0] precision_mode;
  logic mode_change, drain_timeout;
  logic [3:0] inflight;

  typedef struct {
    int cyc;
    int mode;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_fire = 0;

  always #5 clk = ~clk;

  helix_precision_sched #(
    .FEEDBACK_W(16), .DWELL_N(4), .UP_THRESH(1000), .DOWN_THRESH(100), .DRAIN_MAX(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_en(ctrl_en),
    .ctx_valid(ctx_valid), .ctx_ready(ctx_ready),
    .thought_valid(thought_valid), .thought_ready(thought_ready),
    .action_valid(action_valid), .action_ready(action_ready),
    .feedback_valid(feedback_valid), .feedback_delta(feedback_delta),
    .precision_mode(precision_mode), .mode_change(mode_change),
    .inflight(inflight), .drain_timeout(drain_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; every observed mode_change pulse is logged with its cycle.
  task automatic tick();
    ev_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (mode_change === 1'b1) begin
      e.cyc  = cyc;
      e.mode = int'(precision_mode);
      obs_q.push_back(e);
    end
  endtask

  task automatic idle_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic ctx_fires(input int n);
    ctx_valid = 1'b1; ctx_ready = 1'b1;
    repeat (n) tick();
    ctx_valid = 1'b0; ctx_ready = 1'b0;
  endtask

  task automatic thought_fires(input int n);
    thought_valid = 1'b1; thought_ready = 1'b1;
    repeat (n) tick();
    thought_valid = 1'b0; thought_ready = 1'b0;
  endtask

  task automatic thought_at(input int c);
    while (cyc < c - 1) tick();
    thought_fires(1);
  endtask

  // Four action fires with one stalled beat; optional feedback on fire fb_idx.
  task automatic window(input logic fb_en, input int fb_idx, input logic signed [15:0] fb);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        action_valid = 1'b1; action_ready = 1'b0;
        tick();
      end
      action_valid = 1'b1; action_ready = 1'b1;
      if (fb_en && (i == fb_idx)) begin
        feedback_valid = 1'b1; feedback_delta = fb;
      end
      tick();
      action_valid = 1'b0; action_ready = 1'b0; feedback_valid = 1'b0;
    end
    last_fire = cyc;
  endtask

  task automatic expect_sw(input int delay, input int mode);
    ev_t e;
    e.cyc  = last_fire + delay;
    e.mode = mode;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    ev_t o, e;
    int n;
    chk({tag, "_pulses"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_cyc"}, o.cyc, e.cyc);
      chk({tag, "_mode"}, o.mode, e.mode);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic win_and_check(input string tag, input logic fb_en, input int idx,
                               input logic signed [15:0] fb, input logic sw, input int mode);
    window(fb_en, idx, fb);
    if (sw) expect_sw(2, mode);
    idle_until(last_fire + 5);
    sb_check(tag);
    chk({tag, "_mode_now"}, precision_mode, mode);
  endtask

  initial begin
    int f;
    rst_n = 1'b0; ctrl_en = 1'b0;
    ctx_valid = 1'b0; ctx_ready = 1'b0; thought_valid = 1'b0; thought_ready = 1'b0;
    action_valid = 1'b0; action_ready = 1'b0; feedback_valid = 1'b0; feedback_delta = '0;
    repeat (3) tick();
    chk("rst_mode", precision_mode, 0);
    chk("rst_pulse", mode_change, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_timeout", drain_timeout, 0);
    rst_n = 1'b1;
    tick();
    ctrl_en = 1'b1;
    tick();

    // Escalation 0->1->2->3, incl. same-cycle fold and the most negative delta.
    win_and_check("up01", 1'b1, 1, 16'sd1500, 1'b1, 1);
    win_and_check("up12_neg_last", 1'b1, 3, -16'sd2000, 1'b1, 2);
    win_and_check("up23_minneg", 1'b1, 0, 16'sh8000, 1'b1, 3);
    win_and_check("sat3_hold", 1'b1, 2, 16'sd5000, 1'b0, 3);

    // Relax with large feedback during EVAL/DRAIN that must not count.
    window(1'b1, 2, 16'sd50);
    expect_sw(2, 2);
    feedback_valid = 1'b1; feedback_delta = 16'sd30000;
    tick(); tick();
    feedback_valid = 1'b0;
    idle_until(last_fire + 5);
    sb_check("dn32");
    win_and_check("mid_hold", 1'b1, 0, 16'sd500, 1'b0, 2);
    win_and_check("dn21_nofb", 1'b0, 0, 16'sd0, 1'b1, 1);
    win_and_check("dn10", 1'b1, 3, 16'sd50, 1'b1, 0);
    win_and_check("sat0_hold", 1'b1, 1, 16'sd10, 1'b0, 0);
    win_and_check("up_999_hold", 1'b1, 1, 16'sd999, 1'b0, 0);
    win_and_check("up_1000", 1'b1, 1, 16'sd1000, 1'b1, 1);
    win_and_check("dn_100_hold", 1'b1, 2, 16'sd100, 1'b0, 1);
    win_and_check("dn_99", 1'b1, 2, 16'sd99, 1'b1, 0);

    // Drain waits for two outstanding contexts.
    ctx_fires(2);
    tick();
    chk("inflight2", inflight, 2);
    window(1'b1, 0, 16'sd1500);
    f = last_fire;
    expect_sw(11, 1);
    thought_at(f + 5);
    chk("inflight1_drain", inflight, 1);
    thought_at(f + 10);
    idle_until(f + 14);
    sb_check("drain2");
    chk("inflight0_drain", inflight, 0);

    // Forced switch after DRAIN_MAX cycles; timeout flag is sticky.
    ctx_fires(1);
    window(1'b1, 0, 16'sd1500);
    f = last_fire;
    expect_sw(65, 2);
    idle_until(f + 60);
    chk("timeout_pre", drain_timeout, 0);
    idle_until(f + 67);
    sb_check("forced");
    chk("timeout_set", drain_timeout, 1);
    chk("inflight_kept", inflight, 1);
    win_and_check("post_to_hold", 1'b1, 0, 16'sd500, 1'b0, 2);
    chk("timeout_sticky", drain_timeout, 1);
    thought_fires(1);
    chk("inflight_clr", inflight, 0);

    // Disable mid-DRAIN, then inflight tracking while idle.
    ctx_fires(1);
    window(1'b1, 0, 16'sd1500);
    idle_until(last_fire + 3);
    ctrl_en = 1'b0;
    repeat (6) tick();
    sb_check("dis_drain");
    chk("dis_mode", precision_mode, 2);
    ctx_valid = 1'b1; ctx_ready = 1'b1;
    thought_fires(1);
    ctx_valid = 1'b0; ctx_ready = 1'b0;
    chk("inflight_both", inflight, 1);
    ctx_fires(20);
    chk("inflight_sat15", inflight, 15);
    thought_fires(20);
    chk("inflight_sat0", inflight, 0);
    ctrl_en = 1'b1;
    tick();
    win_and_check("reen_hold", 1'b1, 0, 16'sd500, 1'b0, 2);

    // Reset in the middle of a drain abandons the switch.
    ctx_fires(1);
    window(1'b1, 0, 16'sd1500);
    idle_until(last_fire + 3);
    rst_n = 1'b0;
    #2;
    chk("arst_mode", precision_mode, 0);
    chk("arst_timeout", drain_timeout, 0);
    chk("arst_inflight", inflight, 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (5) tick();
    sb_check("arst");
    chk("arst_mode_after", precision_mode, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
